// File: rtl/usb_ep0_transaction_controller_if.sv
// EP0 transaction controller bus bundle.
// Groups the rx, tx and CPU-buffer handshake signals.
interface usb_ep0_transaction_controller_if;
  logic       rx_packet_valid;
  logic [3:0] rx_pid;
  logic [6:0] rx_addr;
  logic [3:0] rx_endp;
  logic       rx_ok;
  logic [6:0] rx_length;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic [6:0] tx_length;
  logic       tx_done;
  logic       out_buffer_ready;
  logic       in_buffer_ready;
  logic [6:0] in_length;
  logic       setup_received;
  logic       out_received;
  logic [6:0] out_length;
  logic       in_complete;
  logic       busy;

  modport master (
    input  rx_packet_valid, rx_pid, rx_addr,
    input  rx_endp, rx_ok, rx_length,
    input  tx_done, out_buffer_ready,
    input  in_buffer_ready, in_length,
    output tx_start, tx_pid, tx_length,
    output setup_received, out_received,
    output out_length, in_complete, busy
  );

  modport slave (
    output rx_packet_valid, rx_pid, rx_addr,
    output rx_endp, rx_ok, rx_length,
    output tx_done, out_buffer_ready,
    output in_buffer_ready, in_length,
    input  tx_start, tx_pid, tx_length,
    input  setup_received, out_received,
    input  out_length, in_complete, busy
  );
endinterface

// File: rtl/usb_ep0_transaction_controller.sv
// USB full-speed EP0 transaction sequencer.
// Token decode, DATA toggles, ACK/NAK choice, gap and timeout.
module usb_ep0_transaction_controller #(
  parameter int CLOCKS_PER_BIT = 4,
  parameter int GAP_BITS       = 2,
  parameter int TIMEOUT_BITS   = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       usb_bus_reset,
  input  logic [6:0] device_address,
  usb_ep0_transaction_controller_if.master bus
);

  localparam int GAP_CYC = GAP_BITS * CLOCKS_PER_BIT;
  localparam int TO_CYC  = TIMEOUT_BITS * CLOCKS_PER_BIT;
  localparam int CW      = $clog2(TO_CYC + 1);

  localparam logic [CW-1:0] TO_END  = CW'(TO_CYC);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    GAP,
    SEND,
    WAIT_TX,
    WAIT_ACK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          kind_setup, kind_n;
  logic          out_tog, out_tog_n;
  logic          in_tog, in_tog_n;
  logic [3:0]    pid_q, pid_n;
  logic [6:0]    len_q, len_n;
  logic [6:0]    olen_q, olen_n;
  logic          setup_q, setup_n;
  logic          outrx_q, outrx_n;
  logic          inc_q, inc_n;
  logic          hs_go;
  logic [3:0]    hs_pid;

  logic rx_good, tok_match, is_data, rx_tog;

  assign rx_good   = bus.rx_packet_valid && bus.rx_ok;
  assign tok_match = rx_good
                  && bus.rx_addr == device_address
                  && bus.rx_endp == 4'd0;
  assign is_data   = bus.rx_pid == PID_DATA0
                  || bus.rx_pid == PID_DATA1;
  assign rx_tog    = bus.rx_pid == PID_DATA1;

  // Next-state, counter, toggle and event decisions
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    kind_n    = kind_setup;
    out_tog_n = out_tog;
    in_tog_n  = in_tog;
    pid_n     = pid_q;
    len_n     = len_q;
    olen_n    = olen_q;
    setup_n   = 1'b0;
    outrx_n   = 1'b0;
    inc_n     = 1'b0;
    hs_go     = 1'b0;
    hs_pid    = PID_ACK;
    unique case (state)
      IDLE: begin
        if (tok_match) begin
          unique case (1'b1)
            bus.rx_pid == PID_SETUP: begin
              state_n = WAIT_DATA;
              kind_n  = 1'b1;
              cnt_n   = ONE;
            end
            bus.rx_pid == PID_OUT: begin
              state_n = WAIT_DATA;
              kind_n  = 1'b0;
              cnt_n   = ONE;
            end
            bus.rx_pid == PID_IN: begin
              state_n = GAP;
              cnt_n   = ONE;
              if (bus.in_buffer_ready) begin
                pid_n = in_tog ? PID_DATA1 : PID_DATA0;
                len_n = bus.in_length;
              end else begin
                pid_n = PID_NAK;
                len_n = 7'd0;
              end
            end
            default: ;
          endcase
        end
      end
      WAIT_DATA: begin
        if (bus.rx_packet_valid) begin
          state_n = IDLE;
          if (bus.rx_ok && is_data) begin
            if (kind_setup) begin
              if (!rx_tog) begin
                hs_go     = 1'b1;
                setup_n   = 1'b1;
                olen_n    = bus.rx_length;
                out_tog_n = 1'b1;
                in_tog_n  = 1'b1;
              end
            end else if (rx_tog != out_tog) begin
              hs_go = 1'b1;
            end else if (!bus.out_buffer_ready) begin
              hs_go  = 1'b1;
              hs_pid = PID_NAK;
            end else begin
              hs_go     = 1'b1;
              outrx_n   = 1'b1;
              olen_n    = bus.rx_length;
              out_tog_n = ~out_tog;
            end
          end
        end else if (cnt == TO_END) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      GAP: begin
        if (cnt >= GAP_END) state_n = SEND;
        else cnt_n = cnt + ONE;
      end
      SEND: state_n = WAIT_TX;
      WAIT_TX: begin
        if (bus.tx_done) begin
          if (pid_q[1:0] == 2'b11) begin
            state_n = WAIT_ACK;
            cnt_n   = ONE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      WAIT_ACK: begin
        if (bus.rx_packet_valid) begin
          state_n = IDLE;
          if (bus.rx_ok && bus.rx_pid == PID_ACK) begin
            in_tog_n = ~in_tog;
            inc_n    = 1'b1;
          end
        end else if (cnt == TO_END) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (hs_go) begin
      state_n = GAP;
      cnt_n   = ONE;
      pid_n   = hs_pid;
      len_n   = 7'd0;
    end
  end

  // State and output registers; bus reset clears like hard reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      kind_setup <= 1'b0;
      out_tog    <= 1'b0;
      in_tog     <= 1'b0;
      pid_q      <= 4'd0;
      len_q      <= 7'd0;
      olen_q     <= 7'd0;
      setup_q    <= 1'b0;
      outrx_q    <= 1'b0;
      inc_q      <= 1'b0;
    end else if (usb_bus_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      kind_setup <= 1'b0;
      out_tog    <= 1'b0;
      in_tog     <= 1'b0;
      pid_q      <= 4'd0;
      len_q      <= 7'd0;
      olen_q     <= 7'd0;
      setup_q    <= 1'b0;
      outrx_q    <= 1'b0;
      inc_q      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      kind_setup <= kind_n;
      out_tog    <= out_tog_n;
      in_tog     <= in_tog_n;
      pid_q      <= pid_n;
      len_q      <= len_n;
      olen_q     <= olen_n;
      setup_q    <= setup_n;
      outrx_q    <= outrx_n;
      inc_q      <= inc_n;
    end
  end

  assign bus.tx_start       = state == SEND;
  assign bus.busy           = state != IDLE;
  assign bus.tx_pid         = pid_q;
  assign bus.tx_length      = len_q;
  assign bus.out_length     = olen_q;
  assign bus.setup_received = setup_q;
  assign bus.out_received   = outrx_q;
  assign bus.in_complete    = inc_q;

endmodule

// File: tb/tb_usb_ep0_transaction_controller.sv
// Bench for the EP0 transaction controller.
// Transaction-level model feeds a scoreboard checked by a monitor.
module tb_usb_ep0_transaction_controller;

  localparam logic [3:0] P_OUT   = 4'b0001;
  localparam logic [3:0] P_IN    = 4'b1001;
  localparam logic [3:0] P_SETUP = 4'b1101;
  localparam logic [3:0] P_D0    = 4'b0011;
  localparam logic [3:0] P_D1    = 4'b1011;
  localparam logic [3:0] P_ACK   = 4'b0010;
  localparam logic [3:0] P_NAK   = 4'b1010;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       usb_bus_reset = 1'b0;
  logic [6:0] device_address = 7'd0;

  usb_ep0_transaction_controller_if bus();

  usb_ep0_transaction_controller dut (
    .clock          (clock),
    .reset          (reset),
    .usb_bus_reset  (usb_bus_reset),
    .device_address (device_address),
    .bus            (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef enum int {EV_TX, EV_SETUP, EV_OUT, EV_INC} ev_e;
  typedef struct {
    ev_e        kind;
    logic [3:0] pid;
    logic [6:0] len;
    int         at;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  // transaction-level model state: next toggles the host must see
  bit   m_out_tog = 1'b0;
  bit   m_in_tog  = 1'b0;

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0d",
               nm, act, req, cyc);
    end
  endtask

  task automatic expect_ev(ev_e k, logic [3:0] p,
                           logic [6:0] l, int at);
    exp_t e;
    e.kind = k;
    e.pid  = p;
    e.len  = l;
    e.at   = at;
    sbq.push_back(e);
  endtask

  task automatic observe(ev_e k, logic [3:0] p,
                         logic [6:0] l);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_output actual=kind%0d pid=%0h required=none t=%0d",
               k, p, cyc);
    end else begin
      e = sbq.pop_front();
      chk("event_kind", int'(k), int'(e.kind));
      chk("event_cycle", cyc, e.at);
      if (e.kind == EV_TX) begin
        chk("tx_pid", p, e.pid);
        chk("tx_length", l, e.len);
      end else if (e.kind != EV_INC) begin
        chk("out_length", l, e.len);
      end
    end
  endtask

  // monitor: every output pulse is matched against the scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.setup_received)
          observe(EV_SETUP, 4'd0, bus.out_length);
        if (bus.out_received)
          observe(EV_OUT, 4'd0, bus.out_length);
        if (bus.in_complete)
          observe(EV_INC, 4'd0, 7'd0);
        if (bus.tx_start)
          observe(EV_TX, bus.tx_pid, bus.tx_length);
      end
    end
  end

  // tx PHY stand-in: finishes each packet 10 cycles after start
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset && bus.tx_start) begin
        repeat (10) @(negedge clock);
        bus.tx_done = 1'b1;
        @(negedge clock);
        bus.tx_done = 1'b0;
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_pkt(logic [3:0] pid, logic [6:0] addr,
                           logic [3:0] endp, bit ok,
                           logic [6:0] len, output int at);
    @(negedge clock);
    bus.rx_pid          = pid;
    bus.rx_addr         = addr;
    bus.rx_endp         = endp;
    bus.rx_ok           = ok;
    bus.rx_length       = len;
    bus.rx_packet_valid = 1'b1;
    at = cyc;
  endtask

  task automatic end_pkt();
    @(negedge clock);
    bus.rx_packet_valid = 1'b0;
  endtask

  task automatic token(logic [3:0] pid, output int at);
    drive_pkt(pid, device_address, 4'd0, 1'b1, 7'd0, at);
  endtask

  task automatic txn_setup(bit d1, bit ready, logic [6:0] len);
    int a;
    bus.out_buffer_ready = ready;
    token(P_SETUP, a);
    end_pkt();
    idle(2);
    drive_pkt(d1 ? P_D1 : P_D0, 7'd0, 4'd0, 1'b1, len, a);
    if (!d1) begin
      expect_ev(EV_SETUP, 4'd0, len, a + 1);
      expect_ev(EV_TX, P_ACK, 7'd0, a + 8);
      m_out_tog = 1'b1;
      m_in_tog  = 1'b1;
    end
    end_pkt();
    idle(30);
  endtask

  task automatic txn_out(bit tog, bit ready, logic [6:0] len);
    int a;
    bus.out_buffer_ready = ready;
    token(P_OUT, a);
    end_pkt();
    idle(2);
    drive_pkt(tog ? P_D1 : P_D0, 7'd0, 4'd0, 1'b1, len, a);
    if (tog != m_out_tog) begin
      expect_ev(EV_TX, P_ACK, 7'd0, a + 8);
    end else if (!ready) begin
      expect_ev(EV_TX, P_NAK, 7'd0, a + 8);
    end else begin
      expect_ev(EV_OUT, 4'd0, len, a + 1);
      expect_ev(EV_TX, P_ACK, 7'd0, a + 8);
      m_out_tog = ~m_out_tog;
    end
    end_pkt();
    idle(30);
  endtask

  // mode 0: host ACKs, 1: host silent, 2: corrupt/other reply
  task automatic txn_in(bit ready, logic [6:0] len, int mode);
    int a;
    bus.in_buffer_ready = ready;
    bus.in_length       = len;
    token(P_IN, a);
    if (ready)
      expect_ev(EV_TX, m_in_tog ? P_D1 : P_D0, len, a + 8);
    else
      expect_ev(EV_TX, P_NAK, 7'd0, a + 8);
    end_pkt();
    bus.in_length = 7'($urandom_range(64));
    if (!ready) begin
      idle(30);
    end else begin
      idle(25);
      if (mode == 0) begin
        drive_pkt(P_ACK, 7'd0, 4'd0, 1'b1, 7'd0, a);
        expect_ev(EV_INC, 4'd0, 7'd0, a + 1);
        m_in_tog = ~m_in_tog;
        end_pkt();
        idle(5);
      end else if (mode == 1) begin
        idle(90);
      end else begin
        if ($urandom_range(1) == 0)
          drive_pkt(P_NAK, 7'd0, 4'd0, 1'b1, 7'd0, a);
        else
          drive_pkt(P_ACK, 7'd0, 4'd0, 1'b0, 7'd0, a);
        end_pkt();
        idle(5);
      end
    end
  endtask

  task automatic txn_junk();
    int          a;
    logic [6:0]  ad;
    logic [3:0]  ep;
    bit          ok;
    logic [3:0]  pids [3];
    pids[0] = P_SETUP;
    pids[1] = P_OUT;
    pids[2] = P_IN;
    ad = device_address;
    ep = 4'd0;
    ok = 1'b1;
    case ($urandom_range(2))
      0: ad = device_address ^ 7'(1 + $urandom_range(126));
      1: ep = 4'(1 + $urandom_range(14));
      default: ok = 1'b0;
    endcase
    drive_pkt(pids[$urandom_range(2)], ad, ep, ok, 7'd0, a);
    end_pkt();
    chk("busy_after_junk", bus.busy, 0);
    idle(10);
  endtask

  initial begin
    int a;
    bus.rx_packet_valid  = 1'b0;
    bus.rx_pid           = 4'd0;
    bus.rx_addr          = 7'd0;
    bus.rx_endp          = 4'd0;
    bus.rx_ok            = 1'b0;
    bus.rx_length        = 7'd0;
    bus.out_buffer_ready = 1'b0;
    bus.in_buffer_ready  = 1'b0;
    bus.in_length        = 7'd0;

    idle(3);
    chk("reset_busy", bus.busy, 0);
    chk("reset_tx_start", bus.tx_start, 0);
    chk("reset_tx_pid", bus.tx_pid, 0);
    chk("reset_tx_length", bus.tx_length, 0);
    chk("reset_out_length", bus.out_length, 0);
    chk("reset_setup_rx", bus.setup_received, 0);
    reset = 1'b0;
    idle(2);

    txn_setup(1'b0, 1'b1, 7'd8);
    txn_in(1'b1, 7'd18, 0);
    txn_in(1'b1, 7'd18, 1);
    txn_in(1'b1, 7'd18, 0);

    txn_out(1'b1, 1'b0, 7'd16);
    txn_out(1'b1, 1'b1, 7'd16);
    txn_out(1'b1, 1'b1, 7'd16);

    device_address = 7'd1;
    drive_pkt(P_SETUP, 7'd0, 4'd0, 1'b1, 7'd0, a);
    end_pkt();
    chk("busy_wrong_addr", bus.busy, 0);
    idle(10);
    drive_pkt(P_IN, 7'd1, 4'd1, 1'b1, 7'd0, a);
    end_pkt();
    chk("busy_wrong_endp", bus.busy, 0);
    idle(10);

    token(P_SETUP, a);
    end_pkt();
    chk("busy_wait_data", bus.busy, 1);
    idle(80);
    chk("busy_after_timeout", bus.busy, 0);

    bus.in_buffer_ready = 1'b1;
    bus.in_length       = 7'd5;
    token(P_IN, a);
    expect_ev(EV_TX, m_in_tog ? P_D1 : P_D0, 7'd5, a + 8);
    end_pkt();
    idle(10);
    reset = 1'b1;
    #1;
    chk("reset_mid_tx_busy", bus.busy, 0);
    chk("reset_mid_tx_start", bus.tx_start, 0);
    m_out_tog = 1'b0;
    m_in_tog  = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(20);

    txn_setup(1'b0, 1'b1, 7'd4);
    @(negedge clock);
    usb_bus_reset = 1'b1;
    idle(2);
    usb_bus_reset = 1'b0;
    m_out_tog = 1'b0;
    m_in_tog  = 1'b0;
    chk("bus_reset_tx_pid", bus.tx_pid, 0);
    txn_in(1'b1, 7'd10, 0);

    for (int i = 0; i < 60; i++) begin
      device_address = 7'($urandom_range(127));
      case ($urandom_range(3))
        0: txn_setup($urandom_range(9) == 0,
                     1'($urandom_range(1)),
                     7'($urandom_range(64)));
        1: txn_out(1'($urandom_range(1)),
                   1'($urandom_range(1)),
                   7'($urandom_range(64)));
        2: txn_in($urandom_range(3) != 0,
                  7'($urandom_range(64)),
                  $urandom_range(2));
        default: txn_junk();
      endcase
    end

    idle(100);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
